// File: rtl/mem8x8_pkg.sv
// Shared constants and state encoding for the 8x8 memory sequencer.
package mem8x8_pkg;

  localparam int unsigned MEM_ADDR_W = 3;
  localparam int unsigned MEM_DATA_W = 8;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    RESP
  } state_t;

endpackage

// File: rtl/mem8x8_ctrl_if.sv
// Request/response channel between a bus master and the 8x8 memory sequencer.
interface mem8x8_ctrl_if
  import mem8x8_pkg::*;
#(
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DATA_W = MEM_DATA_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_write, rsp_rdata
  );

endinterface

// File: rtl/mem8x8_phase_cnt.sv
// 4-bit loadable down-counter timing the SETUP and STROBE phases; parks at zero.
module mem8x8_phase_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  output logic [3:0] o_value,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_value = r_cnt;
  assign o_zero  = (r_cnt == '0);

endmodule

// File: rtl/mem8x8_ctrl.sv
// Initiator-side sequencer for the 8x8 memory: setup phase, multi-cycle strobe,
// then a held response. All outputs are registers so reset drops select at once.
module mem8x8_ctrl
  import mem8x8_pkg::*;
#(
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned DATA_W     = MEM_DATA_W,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  mem8x8_ctrl_if.slave      bus,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_select,
  output logic              mem_rw,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
  localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);

  state_t            r_state;
  logic              r_req_ready;
  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_rw;
  logic              r_sel;

  logic              w_cnt_load;
  logic [3:0]        w_cnt_load_val;
  logic [3:0]        w_cnt_value;
  logic              w_cnt_zero;

  always_comb begin
    w_cnt_load     = 1'b0;
    w_cnt_load_val = STROBE_LD;
    if (r_state == IDLE) begin
      w_cnt_load     = bus.req_valid && r_req_ready;
      w_cnt_load_val = SETUP_LD;
    end else if (r_state == SETUP) begin
      w_cnt_load     = w_cnt_zero;
    end
  end

  mem8x8_phase_cnt u_phase_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .o_value    (w_cnt_value),
    .o_zero     (w_cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rw        <= RW_READ;
      r_sel       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid && r_req_ready) begin
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata;
            r_rw        <= bus.req_write;
            r_rsp_write <= bus.req_write;
            r_req_ready <= 1'b0;
            r_state     <= SETUP;
          end
        end
        SETUP: begin
          if (w_cnt_zero) begin
            r_sel   <= 1'b1;
            r_state <= STROBE;
          end
        end
        STROBE: begin
          if (w_cnt_zero) begin
            r_sel       <= 1'b0;
            r_rsp_rdata <= (r_rw == RW_WRITE) ? '0 : mem_data_out;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          // rw falls with the handshake so the idle memory is left in read mode
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rw        <= RW_READ;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_write = r_rsp_write;
  assign bus.rsp_rdata = r_rsp_rdata;

  assign mem_address = r_addr;
  assign mem_data_in = r_wdata;
  assign mem_select  = r_sel;
  assign mem_rw      = r_rw;

endmodule
